// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI burst controller.
package spi_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_LATCH,
        ST_RD_FETCH,
        ST_RD_LOAD,
        ST_RD_SHIFT,
        ST_WR_SHIFT,
        ST_WR_COMMIT,
        ST_DONE
    } spi_state_e;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_bit_counter.sv
// SCLK bit counter with clear, increment and terminal-count detect.
// last is high on the increment that reaches target.
module spi_bit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic [W-1:0] target,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = inc && (count_q == (target - W'(1)));

endmodule

// File: rtl/spi_burst_ctrl.sv
// SPI slave frame sequencer: command decode, memory strobes, MISO enable.
// Define SPI_BURST_CTRL_BURST_EN for auto-incrementing multi-word frames.
//
// state        | meaning
// IDLE         | waiting for cs low (after cs has been seen high)
// CMD          | shifting address + rw bits
// LATCH        | capture cmd_addr into mem_addr, decode rw
// RD_FETCH     | memory read latency
// RD_LOAD      | parallel-load shift register from memory
// RD_SHIFT     | shifting read word out on MISO
// WR_SHIFT     | shifting write word in
// WR_COMMIT    | write word into memory
// DONE         | frame complete, ignore SCLK until cs high
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic              sclk_pos,
    input  logic              rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              sr_we,
    output logic              dm_we,
    output logic              miso_en,
    output logic              busy,
    output logic              frame_err
);

    localparam int CMD_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(max_i(CMD_W, DATA_W) + 1);

    spi_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              sr_we_q, sr_we_d;
    logic              dm_we_q, dm_we_d;
    logic              miso_en_q, miso_en_d;
    logic              busy_q, busy_d;
    logic              frame_err_q, frame_err_d;
    logic              armed_q, armed_d;

    logic              shifting;
    logic              cnt_inc, cnt_clr, cnt_last;
    logic [CNT_W-1:0]  cnt, cnt_target;

    assign shifting   = (state_q == ST_CMD) || (state_q == ST_RD_SHIFT) || (state_q == ST_WR_SHIFT);
    assign cnt_inc    = shifting && sclk_pos && !cs;
    assign cnt_clr    = (state_d != state_q);
    assign cnt_target = (state_q == ST_CMD) ? CNT_W'(CMD_W) : CNT_W'(DATA_W);

    spi_bit_counter #(.W(CNT_W)) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (cnt_inc),
        .clr    (cnt_clr),
        .target (cnt_target),
        .count  (cnt),
        .last   (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        frame_err_d = 1'b0;
        // A frame may only start once cs has been high since reset.
        armed_d     = armed_q | cs;

        if ((state_q != ST_IDLE) && cs) begin
            state_d     = ST_IDLE;
            frame_err_d = shifting && (cnt != '0);
        end else begin
            case (state_q)
                ST_IDLE:      if (!cs && armed_q) state_d = ST_CMD;
                ST_CMD:       if (cnt_last) state_d = ST_LATCH;
                ST_LATCH: begin
                    mem_addr_d = cmd_addr;
                    state_d    = rw ? ST_RD_FETCH : ST_WR_SHIFT;
                end
                ST_RD_FETCH:  state_d = ST_RD_LOAD;
                ST_RD_LOAD:   state_d = ST_RD_SHIFT;
                ST_RD_SHIFT: begin
                    if (cnt_last) begin
`ifdef SPI_BURST_CTRL_BURST_EN
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        state_d    = ST_RD_FETCH;
`else
                        state_d    = ST_DONE;
`endif
                    end
                end
                ST_WR_SHIFT:  if (cnt_last) state_d = ST_WR_COMMIT;
                ST_WR_COMMIT: begin
`ifdef SPI_BURST_CTRL_BURST_EN
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    state_d    = ST_WR_SHIFT;
`else
                    state_d    = ST_DONE;
`endif
                end
                ST_DONE:      state_d = ST_DONE;
                default:      state_d = ST_IDLE;
            endcase
        end

        sr_we_d   = (state_d == ST_RD_LOAD);
        dm_we_d   = (state_d == ST_WR_COMMIT);
        miso_en_d = (state_d == ST_RD_SHIFT);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= '0;
            sr_we_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            miso_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            sr_we_q     <= sr_we_d;
            dm_we_q     <= dm_we_d;
            miso_en_q   <= miso_en_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            armed_q     <= armed_d;
        end
    end

    // Strobes drop in the same cycle cs rises, ahead of the state change.
    assign sr_we     = sr_we_q & ~cs;
    assign dm_we     = dm_we_q & ~cs;
    assign miso_en   = miso_en_q & ~cs;
    assign mem_addr  = mem_addr_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
